// File: rtl/blackjack_engine.sv
// blackjack_engine: single-player blackjack round sequencer driven by one-cycle
// button pulses, with an internal seedable 16-bit Galois LFSR as card source.
// Successor to blackjack_core; keeps its debug port set.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   btn_start/hit/stand/double one-cycle action pulses
//   rng_load, rng_seed         load a seed into the LFSR (0 loads 16'h0001)
//   user_total, dealer_total   best hand totals (soft aces applied)
//   balance                    bankroll, saturating at 0 and 2^BAL_W-1
//   busy                       round in progress (state != IDLE)
//   round_done                 one-cycle pulse at settlement
//   result                     0 push, 1 win, 2 loss, 3 blackjack
//   dbg_last_card              value of the last drawn card (1..10)
//   dbg_deal_count             initial-deal draws completed (0..3)
//   dbg_blackjack              natural detected in the current/last round
module blackjack_engine #(
  parameter int BAL_W        = 10,
  parameter int START_BAL    = 500,
  parameter int STAKE        = 50,
  parameter int BJ_PAY       = 150,
  parameter int DEALER_STAND = 17,
  parameter int HIT_SOFT17   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_start,
  input  logic             btn_hit,
  input  logic             btn_stand,
  input  logic             btn_double,
  input  logic             rng_load,
  input  logic [15:0]      rng_seed,
  output logic [5:0]       user_total,
  output logic [5:0]       dealer_total,
  output logic [BAL_W-1:0] balance,
  output logic             busy,
  output logic             round_done,
  output logic [1:0]       result,
  output logic [4:0]       dbg_last_card,
  output logic [1:0]       dbg_deal_count,
  output logic             dbg_blackjack
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DEAL   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_PLAYER = 3'd3;
  localparam logic [2:0] S_DEALER = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;

  localparam int               EXT_W    = BAL_W + 2;
  localparam logic [EXT_W-1:0] STAKE_X  = EXT_W'(STAKE);
  localparam logic [EXT_W-1:0] STAKE2_X = EXT_W'(2 * STAKE);
  localparam logic [EXT_W-1:0] BJ_X     = EXT_W'(BJ_PAY);
  localparam logic [EXT_W-1:0] MAX_X    = EXT_W'((1 << BAL_W) - 1);
  localparam logic [5:0]       STAND_T  = 6'(DEALER_STAND);

  logic [2:0]  state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_step;
  logic [5:0]  user_hard;
  logic [5:0]  dealer_hard;
  logic        user_ace;
  logic        dealer_ace;
  logic [1:0]  user_cards;
  logic        doubled;

  logic [3:0]  r_raw;
  logic [3:0]  r_mod;
  logic [4:0]  rank;
  logic [4:0]  card_val;
  logic [5:0]  card6;
  logic        card_ace;

  logic [5:0]  user_best;
  logic [5:0]  dealer_best;
  logic        dealer_soft;
  logic [5:0]  user_hit_total;
  logic [1:0]  user_cards_inc;
  logic        dealer_draw;

  logic [EXT_W-1:0] bal_x;
  logic [EXT_W-1:0] bet_x;
  logic [EXT_W-1:0] sum;
  logic [BAL_W-1:0] bal_next;
  logic [1:0]       res_next;
  logic             can_start;
  logic             can_double;

  // Galois step: shift right, fold taps in when the bit shifted out is 1.
  always_comb begin
    lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  end

  // Card from the low nibble: fold 13..15 back onto 0..2, ranks 1..13, faces are 10.
  always_comb begin
    r_raw    = lfsr[3:0];
    r_mod    = (r_raw >= 4'd13) ? (r_raw - 4'd13) : r_raw;
    rank     = {1'b0, r_mod} + 5'd1;
    card_val = (rank > 5'd10) ? 5'd10 : rank;
    card6    = {1'b0, card_val};
    card_ace = (card_val == 5'd1);
  end

  // An ace is promoted to 11 only while that cannot bust the hand.
  always_comb begin
    user_best      = (user_ace && user_hard <= 6'd11) ? user_hard + 6'd10 : user_hard;
    dealer_soft    = dealer_ace && (dealer_hard <= 6'd11);
    dealer_best    = dealer_soft ? dealer_hard + 6'd10 : dealer_hard;
    user_hit_total = user_hard + card6;
    user_cards_inc = (user_cards == 2'd3) ? 2'd3 : user_cards + 2'd1;
    dealer_draw    = (dealer_best < STAND_T) ||
                     ((HIT_SOFT17 != 0) && (dealer_best == STAND_T) && dealer_soft);
  end

  // Settlement runs two bits wider than the bankroll so that underflow shows up
  // as a set top bit and overflow as a value above MAX_X; both are clamped.
  always_comb begin
    bal_x      = {2'b00, balance};
    bet_x      = doubled ? STAKE2_X : STAKE_X;
    can_start  = (bal_x >= STAKE_X);
    can_double = (user_cards == 2'd2) && (bal_x >= STAKE2_X);
    sum        = bal_x;
    res_next   = 2'd0;
    if (dbg_blackjack) begin
      sum      = bal_x + BJ_X;
      res_next = 2'd3;
    end else if (user_hard > 6'd21) begin
      sum      = bal_x - bet_x;
      res_next = 2'd2;
    end else if ((dealer_hard > 6'd21) || (user_best > dealer_best)) begin
      sum      = bal_x + bet_x;
      res_next = 2'd1;
    end else if (user_best < dealer_best) begin
      sum      = bal_x - bet_x;
      res_next = 2'd2;
    end
    if (sum[EXT_W-1]) begin
      bal_next = '0;
    end else if (sum > MAX_X) begin
      bal_next = '1;
    end else begin
      bal_next = sum[BAL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      lfsr           <= 16'hACE1;
      balance        <= BAL_W'(START_BAL);
      user_hard      <= '0;
      dealer_hard    <= '0;
      user_ace       <= 1'b0;
      dealer_ace     <= 1'b0;
      user_cards     <= '0;
      doubled        <= 1'b0;
      round_done     <= 1'b0;
      result         <= '0;
      dbg_last_card  <= '0;
      dbg_deal_count <= '0;
      dbg_blackjack  <= 1'b0;
    end else begin
      round_done <= 1'b0;
      if (rng_load) begin
        lfsr <= (rng_seed == 16'h0000) ? 16'h0001 : rng_seed;
      end else begin
        lfsr <= lfsr_step;
      end

      case (state)
        S_IDLE: begin
          if (btn_start && can_start) begin
            state          <= S_DEAL;
            user_hard      <= '0;
            dealer_hard    <= '0;
            user_ace       <= 1'b0;
            dealer_ace     <= 1'b0;
            user_cards     <= '0;
            doubled        <= 1'b0;
            result         <= '0;
            dbg_deal_count <= '0;
            dbg_blackjack  <= 1'b0;
          end
        end

        S_DEAL: begin
          dbg_last_card  <= card_val;
          dbg_deal_count <= dbg_deal_count + 2'd1;
          if (dbg_deal_count == 2'd2) begin
            dealer_hard <= dealer_hard + card6;
            dealer_ace  <= dealer_ace | card_ace;
            state       <= S_CHECK;
          end else begin
            user_hard  <= user_hit_total;
            user_ace   <= user_ace | card_ace;
            user_cards <= user_cards_inc;
          end
        end

        S_CHECK: begin
          if ((user_cards == 2'd2) && (user_best == 6'd21)) begin
            dbg_blackjack <= 1'b1;
            state         <= S_SETTLE;
          end else begin
            state <= S_PLAYER;
          end
        end

        S_PLAYER: begin
          if (btn_stand) begin
            state <= S_DEALER;
          end else if (btn_double && can_double) begin
            doubled       <= 1'b1;
            user_hard     <= user_hit_total;
            user_ace      <= user_ace | card_ace;
            user_cards    <= user_cards_inc;
            dbg_last_card <= card_val;
            state         <= (user_hit_total > 6'd21) ? S_SETTLE : S_DEALER;
          end else if (btn_hit) begin
            user_hard     <= user_hit_total;
            user_ace      <= user_ace | card_ace;
            user_cards    <= user_cards_inc;
            dbg_last_card <= card_val;
            if (user_hit_total > 6'd21) begin
              state <= S_SETTLE;
            end
          end
        end

        S_DEALER: begin
          if (dealer_draw) begin
            dealer_hard   <= dealer_hard + card6;
            dealer_ace    <= dealer_ace | card_ace;
            dbg_last_card <= card_val;
          end else begin
            state <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          balance    <= bal_next;
          result     <= res_next;
          round_done <= 1'b1;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state != S_IDLE);
  assign user_total   = user_best;
  assign dealer_total = dealer_best;

endmodule

// File: tb/tb_blackjack_engine.sv
// tb_blackjack_engine: directed bench for blackjack_engine. Five instances share
// one stimulus stream: default (500), START_BAL 40, START_BAL 60, START_BAL 1000
// and HIT_SOFT17=1. Cards are steered by loading seeds whose low nibble fixes the
// next draw; one round uses free-running LFSR steps from seed 16'h0001.
module tb_blackjack_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_start;
  logic        btn_hit;
  logic        btn_stand;
  logic        btn_double;
  logic        rng_load;
  logic [15:0] rng_seed;

  logic [5:0] ut  [5];
  logic [5:0] dt  [5];
  logic [9:0] bal [5];
  logic       bsy [5];
  logic       rd  [5];
  logic [1:0] res [5];
  logic [4:0] lc  [5];
  logic [1:0] dc  [5];
  logic       bj  [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    blackjack_engine #(
      .BAL_W       (10),
      .START_BAL   ((g == 1) ? 40 : (g == 2) ? 60 : (g == 3) ? 1000 : 500),
      .STAKE       (50),
      .BJ_PAY      (150),
      .DEALER_STAND(17),
      .HIT_SOFT17  ((g == 4) ? 1 : 0)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_start     (btn_start),
      .btn_hit       (btn_hit),
      .btn_stand     (btn_stand),
      .btn_double    (btn_double),
      .rng_load      (rng_load),
      .rng_seed      (rng_seed),
      .user_total    (ut[g]),
      .dealer_total  (dt[g]),
      .balance       (bal[g]),
      .busy          (bsy[g]),
      .round_done    (rd[g]),
      .result        (res[g]),
      .dbg_last_card (lc[g]),
      .dbg_deal_count(dc[g]),
      .dbg_blackjack (bj[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_tick(input logic st, input logic ld, input logic [15:0] sd,
                            input logic h, input logic s, input logic d);
    btn_start  = st;
    rng_load   = ld;
    rng_seed   = sd;
    btn_hit    = h;
    btn_stand  = s;
    btn_double = d;
    tick();
    btn_start  = 1'b0;
    rng_load   = 1'b0;
    rng_seed   = 16'h0000;
    btn_hit    = 1'b0;
    btn_stand  = 1'b0;
    btn_double = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic int start_bal(input int i);
    return (i == 1) ? 40 : (i == 2) ? 60 : (i == 3) ? 1000 : 500;
  endfunction

  initial begin
    int pulses;
    rst_n = 1'b0; btn_start = 1'b0; btn_hit = 1'b0; btn_stand = 1'b0;
    btn_double = 1'b0; rng_load = 1'b0; rng_seed = 16'h0000;

    // Reset state on every instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst_bal%0d", i),  32'(bal[i]), 32'(start_bal(i)));
      chk($sformatf("rst_ut%0d", i),   32'(ut[i]),  32'd0);
      chk($sformatf("rst_dt%0d", i),   32'(dt[i]),  32'd0);
      chk($sformatf("rst_busy%0d", i), 32'(bsy[i]), 32'd0);
      chk($sformatf("rst_dc%0d", i),   32'(dc[i]),  32'd0);
      chk($sformatf("rst_rd%0d", i),   32'(rd[i]),  32'd0);
      chk($sformatf("rst_res%0d", i),  32'(res[i]), 32'd0);
      chk($sformatf("rst_bj%0d", i),   32'(bj[i]),  32'd0);
      chk($sformatf("rst_lc%0d", i),   32'(lc[i]),  32'd0);
    end

    // Standard round, free-running LFSR from seed 1:
    // draws 0001->2, B400->A, 5A00->A(dealer); dealer then A,A,A,9,5 -> 18; player 13 loses
    drive_tick(1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("a_busy",     32'(bsy[0]), 32'd1);
    chk("a_dc0",      32'(dc[0]),  32'd0);
    chk("a_lo_guard", 32'(bsy[1]), 32'd0);
    chk("a_mid_busy", 32'(bsy[2]), 32'd1);
    tick();
    chk("a_dc1", 32'(dc[0]), 32'd1);
    chk("a_ut1", 32'(ut[0]), 32'd2);
    chk("a_lc1", 32'(lc[0]), 32'd2);
    tick();
    chk("a_dc2", 32'(dc[0]), 32'd2);
    chk("a_ut2", 32'(ut[0]), 32'd13);
    tick();
    chk("a_dc3", 32'(dc[0]), 32'd3);
    chk("a_dt3", 32'(dt[0]), 32'd11);
    chk("a_lc3", 32'(lc[0]), 32'd1);
    tick();
    chk("a_bj",        32'(bj[0]),  32'd0);
    chk("a_busy_play", 32'(bsy[0]), 32'd1);
    chk("a_lo_idle",   32'(bsy[1]), 32'd0);
    drive_tick(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("a_dt_stand", 32'(dt[0]), 32'd11);
    tick();
    chk("a_dt_first", 32'(dt[0]), 32'd12);
    repeat (5) tick();
    chk("a_dt_final", 32'(dt[0]), 32'd18);
    chk("a_rd_pre",   32'(rd[0]),  32'd0);
    tick();
    chk("a_rd",   32'(rd[0]),  32'd1);
    chk("a_bal",  32'(bal[0]), 32'd450);
    chk("a_res",  32'(res[0]), 32'd2);
    chk("a_idle", 32'(bsy[0]), 32'd0);
    chk("a_ut",   32'(ut[0]),  32'd13);
    tick();
    chk("a_rd_once", 32'(rd[0]), 32'd0);

    // Natural: A, 10 to player, 6 to dealer; settles one cycle after CHECK
    drive_tick(1'b1, 1'b1, 16'h000D, 1'b0, 1'b0, 1'b0);
    chk("b_busy", 32'(bsy[0]), 32'd1);
    drive_tick(1'b0, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0);
    chk("b_ut1", 32'(ut[0]), 32'd11);
    drive_tick(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    chk("b_ut2", 32'(ut[0]), 32'd21);
    tick();
    chk("b_dt", 32'(dt[0]), 32'd6);
    tick();
    chk("b_bj",    32'(bj[0]), 32'd1);
    chk("b_rd_pre", 32'(rd[0]), 32'd0);
    tick();
    chk("b_rd",   32'(rd[0]),  32'd1);
    chk("b_bal",  32'(bal[0]), 32'd600);
    chk("b_res",  32'(res[0]), 32'd3);
    chk("b_idle", 32'(bsy[0]), 32'd0);
    chk("b_dt_held", 32'(dt[0]), 32'd6);
    tick();
    chk("b_rd_once", 32'(rd[0]),  32'd0);
    chk("b_bj_held", 32'(bj[0]),  32'd1);
    chk("b_res_held", 32'(res[0]), 32'd3);

    // Double: player 5+6, dealer 10; double draws K -> 21; dealer draws 8 -> 18.
    // START_BAL 60 ignores the double; START_BAL 1000 wins 100 and saturates.
    do_reset();
    drive_tick(1'b1, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0);
    chk("c_lo_guard", 32'(bsy[1]), 32'd0);
    chk("c_mid_busy", 32'(bsy[2]), 32'd1);
    drive_tick(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    drive_tick(1'b0, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0);
    tick();
    chk("c_ut_deal", 32'(ut[0]), 32'd11);
    chk("c_dt_deal", 32'(dt[0]), 32'd10);
    tick();
    drive_tick(1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
    drive_tick(1'b0, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b1);
    chk("c_ut_dbl",      32'(ut[0]),  32'd21);
    chk("c_mid_ignored", 32'(ut[2]),  32'd11);
    chk("c_mid_busy2",   32'(bsy[2]), 32'd1);
    chk("c_mid_bal",     32'(bal[2]), 32'd60);
    drive_tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("c_hit_ignored", 32'(ut[0]), 32'd21);
    chk("c_dt_draw",     32'(dt[0]), 32'd18);
    chk("c_mid_hit",     32'(ut[2]), 32'd19);
    tick();
    chk("c_rd_pre", 32'(rd[0]), 32'd0);
    tick();
    chk("c_rd",     32'(rd[0]),  32'd1);
    chk("c_bal",    32'(bal[0]), 32'd600);
    chk("c_res",    32'(res[0]), 32'd1);
    chk("c_hi_rd",  32'(rd[3]),  32'd1);
    chk("c_hi_sat", 32'(bal[3]), 32'd1023);

    // Soft 17: player 10+9, dealer A then 6. Default stands and loses to 19;
    // HIT_SOFT17 draws a 2 to reach 19 and pushes.
    do_reset();
    drive_tick(1'b1, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0);
    drive_tick(1'b0, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0);
    drive_tick(1'b0, 1'b1, 16'h000D, 1'b0, 1'b0, 1'b0);
    tick();
    chk("d_ut",     32'(ut[0]), 32'd19);
    chk("d_dt",     32'(dt[0]), 32'd11);
    chk("d_s17_dt", 32'(dt[4]), 32'd11);
    tick();
    drive_tick(1'b0, 1'b1, 16'h0005, 1'b0, 1'b1, 1'b0);
    chk("d_dt_stand", 32'(dt[0]), 32'd11);
    drive_tick(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("d_dt_s17",  32'(dt[0]), 32'd17);
    chk("d_dt4_s17", 32'(dt[4]), 32'd17);
    tick();
    chk("d_dt_hold",  32'(dt[0]), 32'd17);
    chk("d_dt4_hit",  32'(dt[4]), 32'd19);
    chk("d_rd_pre",   32'(rd[0]), 32'd0);
    tick();
    chk("d_rd",      32'(rd[0]),  32'd1);
    chk("d_bal",     32'(bal[0]), 32'd550);
    chk("d_res",     32'(res[0]), 32'd1);
    chk("d_rd4_pre", 32'(rd[4]),  32'd0);
    tick();
    chk("d_rd4",      32'(rd[4]),  32'd1);
    chk("d_bal4",     32'(bal[4]), 32'd500);
    chk("d_res4",     32'(res[4]), 32'd0);
    chk("d_rd_once",  32'(rd[0]),  32'd0);

    // Abort: reset during DEALER discards the round with no settlement
    do_reset();
    drive_tick(1'b1, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0);
    drive_tick(1'b0, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0);
    drive_tick(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive_tick(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("e_hi_busy", 32'(bsy[3]), 32'd1);
    chk("e_hi_dt",   32'(dt[3]),  32'd2);
    rst_n = 1'b0;
    tick();
    chk("e_hi_bal",  32'(bal[3]), 32'd1000);
    chk("e_hi_idle", 32'(bsy[3]), 32'd0);
    chk("e_hi_rd",   32'(rd[3]),  32'd0);
    chk("e_hi_ut",   32'(ut[3]),  32'd0);
    chk("e_hi_dt0",  32'(dt[3]),  32'd0);
    chk("e_hi_dc",   32'(dc[3]),  32'd0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      tick();
      if (rd[3]) pulses++;
    end
    chk("e_no_settle", 32'(pulses), 32'd0);
    chk("e_hi_bal2",   32'(bal[3]), 32'd1000);

    // Player bust on a hit; dealer seeded with 0, which loads 1 and deals a 2
    do_reset();
    drive_tick(1'b1, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0);
    drive_tick(1'b0, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0);
    drive_tick(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("f_ut",        32'(ut[0]), 32'd20);
    chk("f_zero_seed", 32'(dt[0]), 32'd2);
    tick();
    drive_tick(1'b0, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0);
    drive_tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("f_ut_bust", 32'(ut[0]),  32'd30);
    chk("f_busy",    32'(bsy[0]), 32'd1);
    tick();
    chk("f_rd",      32'(rd[0]),  32'd1);
    chk("f_bal",     32'(bal[0]), 32'd450);
    chk("f_res",     32'(res[0]), 32'd2);
    chk("f_dt_skip", 32'(dt[0]),  32'd2);
    chk("f_idle",    32'(bsy[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
